sseg_scan: RTL and testbench

- Time-multiplexed scan controller for the 6-digit seven-segment display; drives the per-digit value/position inputs of the segment encoder.
- Holds a double-buffered frame of six BCD digits plus decimal-point flags and walks digit_pos 0..5 at a fixed slot rate.
- Inserts a blanking interval before each slot to prevent ghosting.
- Frames are loaded from the clock/time logic through a valid/ready handshake and take effect only at frame boundaries, so the display never tears.

---
 rtl/sseg_pkg.sv | 31 +++
 rtl/sseg_slot_timer.sv | 51 +++++
 rtl/sseg_scan.sv | 108 ++++++++++
 tb/tb_sseg_scan.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the six-digit seven-segment scan controller.
package sseg_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef logic [4:0] digit_t;

  localparam bcd_t BCD_BLANK = 4'hF;

  typedef enum logic {ST_BLANK, ST_SHOW} slot_state_t;

  function automatic int clog2(input int value);
    int width;
    int rest;
    width = 0;
    rest = value - 1;
    while (rest > 0) begin
      width++;
      rest = rest >> 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

  // Position p occupies bits [4p+3:4p] of a packed frame.
  function automatic bcd_t nibble_at(input logic [4*NUM_DIGITS-1:0] frame,
                                     input logic [2:0] pos);
    return bcd_t'(frame >> {pos, 2'b00});
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Free-running slot counter with a two-state blank/show FSM; slot timing never stalls.
module sseg_slot_timer
  import sseg_pkg::*;
#(
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_slot_end,
  output logic o_blank_end,
  output logic o_digit_en_raw
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV) begin : g_bad_blank
    $error("sseg_slot_timer: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DIV");
  end

  slot_state_t   r_state;
  logic [CW-1:0] r_count;
  logic          r_en_raw;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count  <= '0;
      r_state  <= ST_BLANK;
      r_en_raw <= 1'b0;
    end else begin
      r_count <= (r_count == SLOT_LAST) ? '0 : r_count + 1'b1;
      case (r_state)
        ST_BLANK: if (r_count == BLANK_LAST) begin
          r_state  <= ST_SHOW;
          r_en_raw <= 1'b1;
        end
        ST_SHOW: if (r_count == SLOT_LAST) begin
          r_state  <= ST_BLANK;
          r_en_raw <= 1'b0;
        end
      endcase
    end
  end

  assign o_slot_end     = (r_count == SLOT_LAST);
  assign o_blank_end    = (r_count == BLANK_LAST);
  assign o_digit_en_raw = r_en_raw;

endmodule

// File: rtl/sseg_scan.sv
// Scan controller: double-buffered six-digit frame, valid/ready loading, and
// position sequencing that swaps frames only when leaving position 5.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int SLOT_HZ      = 1000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_frame_bcd,
  input  logic [NUM_DIGITS-1:0]   i_frame_dp,
  input  logic                    i_frame_valid,
  output logic                    o_frame_ready,
  output digit_t                  o_digit,
  output logic [2:0]              o_digit_pos,
  output logic                    o_digit_en,
  output logic                    o_frame_start
);

  localparam int DIV = CLK_HZ / SLOT_HZ;
  localparam int FW  = 4 * NUM_DIGITS;

  logic w_slot_end, w_blank_end, w_en_raw;
  logic w_accept, w_boundary;
  logic [2:0] w_next_pos;
  logic [FW-1:0] w_new_bcd;
  logic [NUM_DIGITS-1:0] w_new_dp;

  logic [FW-1:0] r_act_bcd, r_pend_bcd;
  logic [NUM_DIGITS-1:0] r_act_dp, r_pend_dp;
  logic r_pend_full, r_visible, r_frame_start;
  logic [2:0] r_pos;
  digit_t r_digit;

  sseg_slot_timer #(
    .DIV          (DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .o_slot_end     (w_slot_end),
    .o_blank_end    (w_blank_end),
    .o_digit_en_raw (w_en_raw)
  );

  assign w_accept   = i_frame_valid && !r_pend_full;
  assign w_boundary = w_slot_end && (r_pos == 3'(NUM_DIGITS - 1));
  assign w_next_pos = w_boundary ? 3'd0 : r_pos + 3'd1;

  // Frame that becomes active after this edge: pending wins, else a same-cycle offer bypasses.
  always_comb begin
    w_new_bcd = r_act_bcd;
    w_new_dp  = r_act_dp;
    if (w_boundary && r_pend_full) begin
      w_new_bcd = r_pend_bcd;
      w_new_dp  = r_pend_dp;
    end else if (w_boundary && w_accept) begin
      w_new_bcd = i_frame_bcd;
      w_new_dp  = i_frame_dp;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act_bcd   <= {NUM_DIGITS{BCD_BLANK}};
      r_act_dp    <= '0;
      r_pend_bcd  <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
    end else if (w_boundary) begin
      r_act_bcd   <= w_new_bcd;
      r_act_dp    <= w_new_dp;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pend_bcd  <= i_frame_bcd;
      r_pend_dp   <= i_frame_dp;
      r_pend_full <= 1'b1;
    end
  end

  // Digit and position move only on blank entry; visibility is decided from the active nibble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pos         <= '0;
      r_digit       <= '0;
      r_visible     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      if (w_slot_end) begin
        r_pos   <= w_next_pos;
        r_digit <= {w_new_dp[w_next_pos], nibble_at(w_new_bcd, w_next_pos)};
      end
      if (w_blank_end) begin
        r_visible <= (nibble_at(r_act_bcd, r_pos) <= 4'd9);
      end
    end
  end

  assign o_frame_ready = !r_pend_full;
  assign o_digit       = r_digit;
  assign o_digit_pos   = r_pos;
  assign o_digit_en    = w_en_raw && r_visible;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_sseg_scan.sv
// Scoreboard bench for sseg_scan: accepted frames queue up and retire at frame boundaries.
`timescale 1ns/1ps
module tb_sseg_scan;

  localparam int DIV   = 12;
  localparam int FRAME = 6 * DIV;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [23:0] i_frame_bcd = '0;
  logic [5:0]  i_frame_dp = '0;
  logic        i_frame_valid = 1'b0;
  logic        o_frame_ready;
  logic [4:0]  o_digit;
  logic [2:0]  o_digit_pos;
  logic        o_digit_en;
  logic        o_frame_start;

  sseg_scan #(
    .CLK_HZ       (1200),
    .SLOT_HZ      (100),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_frame_bcd   (i_frame_bcd),
    .i_frame_dp    (i_frame_dp),
    .i_frame_valid (i_frame_valid),
    .o_frame_ready (o_frame_ready),
    .o_digit       (o_digit),
    .o_digit_pos   (o_digit_pos),
    .o_digit_en    (o_digit_en),
    .o_frame_start (o_frame_start)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit monOn = 1'b0;

  logic [29:0] expFrames[$];
  logic [23:0] actBcd = '1;
  logic [5:0]  actDp = '0;

  int          mPos;
  int          mSlotCnt;
  logic [3:0]  mNib;
  logic [4:0]  mDigit;
  logic [29:0] mFrame;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [3:0] nib(input logic [23:0] f, input int p);
    logic [23:0] t;
    t = f >> (4 * p);
    return t[3:0];
  endfunction

  // Cycle-by-cycle comparison, then the scoreboard absorbs what the coming edge does.
  always @(negedge i_clk) begin
    if (monOn) begin
      mSlotCnt = cyc % DIV;
      mPos     = (cyc / DIV) % 6;
      mNib     = nib(actBcd, mPos);
      mDigit   = (cyc < DIV) ? 5'd0 : {actDp[mPos], mNib};
      checkOutput("digit_pos", 32'(o_digit_pos), 32'(mPos));
      checkOutput("digit", 32'(o_digit), 32'(mDigit));
      checkOutput("digit_en", 32'(o_digit_en), 32'(mSlotCnt >= 2 && mNib <= 4'd9));
      checkOutput("frame_start", 32'(o_frame_start), 32'(cyc % FRAME == 0 && cyc != 0));
      checkOutput("frame_ready", 32'(o_frame_ready), 32'(expFrames.size() == 0));
      if (i_frame_valid && expFrames.size() == 0)
        expFrames.push_back({i_frame_dp, i_frame_bcd});
      if (cyc % FRAME == FRAME - 1 && expFrames.size() > 0) begin
        mFrame = expFrames.pop_front();
        actDp  = mFrame[29:24];
        actBcd = mFrame[23:0];
      end
      cyc++;
    end
  end

  task automatic applyReset();
    monOn = 1'b0;
    i_rst = 1'b1;
    #1;
    checkOutput("rst_digit", 32'(o_digit), 32'd0);
    checkOutput("rst_digit_pos", 32'(o_digit_pos), 32'd0);
    checkOutput("rst_digit_en", 32'(o_digit_en), 32'd0);
    checkOutput("rst_frame_start", 32'(o_frame_start), 32'd0);
    checkOutput("rst_frame_ready", 32'(o_frame_ready), 32'd1);
    expFrames.delete();
    actBcd = '1;
    actDp  = '0;
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    cyc   = 0;
    monOn = 1'b1;
  endtask

  // Call at posedge+1; holds the offer until the DUT takes it, then scrambles the data lines.
  task automatic applyStimulus(input logic [23:0] bcd, input logic [5:0] dp);
    bit done;
    done          = 1'b0;
    i_frame_bcd   = bcd;
    i_frame_dp    = dp;
    i_frame_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge i_clk);
      done = o_frame_ready;
      @(posedge i_clk);
      #1;
    end
    i_frame_valid = 1'b0;
    i_frame_bcd   = 24'($urandom);
    i_frame_dp    = 6'($urandom);
    checkOutput("accepted", 32'(done), 32'd1);
  endtask

  task automatic waitPhase(input int phase);
    for (int i = 0; i < 200; i++) begin
      @(posedge i_clk);
      #1;
      if (cyc % FRAME == phase) break;
    end
  endtask

  initial begin
    #2;
    applyReset();
    repeat (150) @(posedge i_clk);

    waitPhase(5);
    applyStimulus(24'h123456, 6'b000100);
    applyStimulus(24'h98A765, 6'b100001);
    repeat (160) @(posedge i_clk);

    waitPhase(FRAME - 1);
    i_frame_bcd   = 24'h013579;
    i_frame_dp    = 6'b010010;
    i_frame_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_frame_valid = 1'b0;
    repeat (100) @(posedge i_clk);

    waitPhase(2);
    applyStimulus(24'h555555, 6'b111111);
    waitPhase(50);
    #2;
    applyReset();
    repeat (150) @(posedge i_clk);

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
